// File: rtl/hc165_rd_if.sv
// hc165_rd bus: start request, '165 chain pins and captured-word outputs.
// The master side is user logic plus the board chain; the slave side is the reader.
interface hc165_rd_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic             q7;
    logic             pl_n;
    logic             ce_n;
    logic             cp;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;

    modport master (
        output start,
        output q7,
        input  pl_n,
        input  ce_n,
        input  cp,
        input  data_out,
        input  data_valid,
        input  busy
    );

    modport slave (
        input  start,
        input  q7,
        output pl_n,
        output ce_n,
        output cp,
        output data_out,
        output data_valid,
        output busy
    );
endinterface

// File: rtl/hc165_rd.sv
// hc165_rd: 74HC165 chain reader, MSB-first, one-cycle valid strobe per frame.
// Optional macro HC165_SYNC_EN: put q7 through a 2-flop synchroniser.
module hc165_rd #(
    parameter int CNT_MAX = 2,
    parameter int WIDTH   = 16
) (
    input logic        clk,
    input logic        rst_n,
    hc165_rd_if.slave  bus
);
    localparam int DW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PW = $clog2(2 * WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             pl_n_q, pl_n_d;
    logic             ce_n_q, ce_n_d;
    logic             cp_q, cp_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             q7_s;
    logic             tick;

`ifdef HC165_SYNC_EN
    logic q7_m_q, q7_s_q;

    // Two-flop synchroniser for the asynchronous board q7 line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q7_m_q <= 1'b0;
            q7_s_q <= 1'b0;
        end else begin
            q7_m_q <= bus.q7;
            q7_s_q <= q7_m_q;
        end
    end

    assign q7_s = q7_s_q;
`else
    assign q7_s = bus.q7;
`endif

    assign tick = (div_q == DW'(CNT_MAX - 1));

    // Next-state logic: divider, frame sequencing and pin waveforms.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        phase_d = phase_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        pl_n_d  = pl_n_q;
        ce_n_d  = ce_n_q;
        cp_d    = cp_q;
        valid_d = 1'b0;
        if (state_q != IDLE) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                div_d = '0;
                if (bus.start) begin
                    state_d = LOAD;
                    pl_n_d  = 1'b0;
                end
            end
            LOAD: begin
                if (tick) begin
                    pl_n_d  = 1'b1;
                    ce_n_d  = 1'b0;
                    phase_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!phase_q[0]) begin
                        shreg_d = {shreg_q[WIDTH-2:0], q7_s};
                        cp_d    = 1'b1;
                    end else begin
                        cp_d = 1'b0;
                    end
                    if (phase_q == PW'(2 * WIDTH - 1)) begin
                        ce_n_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            DONE: begin
                data_d  = shreg_q;
                valid_d = 1'b1;
                div_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            phase_q <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            pl_n_q  <= 1'b1;
            ce_n_q  <= 1'b1;
            cp_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            pl_n_q  <= pl_n_d;
            ce_n_q  <= ce_n_d;
            cp_q    <= cp_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.pl_n       = pl_n_q;
    assign bus.ce_n       = ce_n_q;
    assign bus.cp         = cp_q;
    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_hc165_rd.sv
// tb_hc165_rd: two readers (16b/div2 and 8b/div5) against behavioural '165 chains.
// Expected words and valid cycles are queued at start; monitors pop on data_valid.
module tb_hc165_rd;
    localparam int W1 = 16;
    localparam int C1 = 2;
    localparam int W2 = 8;
    localparam int C2 = 5;
    localparam int L1 = (2 * W1 + 1) * C1 + 1;
    localparam int L2 = (2 * W2 + 1) * C2 + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hc165_rd_if #(.WIDTH(W1)) b1 ();
    hc165_rd_if #(.WIDTH(W2)) b2 ();

    hc165_rd #(.CNT_MAX(C1), .WIDTH(W1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    hc165_rd #(.CNT_MAX(C2), .WIDTH(W2)) u2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int overlap = 0;
    int vcount1 = 0;
    int vcount2 = 0;

    // Behavioural '165 chains: async parallel load, shift on cp rise.
    logic [W1-1:0] val1 = '0;
    logic [W1-1:0] sr1 = '0;
    logic [W2-1:0] val2 = '0;
    logic [W2-1:0] sr2 = '0;

    always @(posedge b1.cp or negedge b1.pl_n) begin
        if (!b1.pl_n) sr1 <= val1;
        else if (!b1.ce_n) sr1 <= {sr1[W1-2:0], 1'b0};
    end
    always @(posedge b2.cp or negedge b2.pl_n) begin
        if (!b2.pl_n) sr2 <= val2;
        else if (!b2.ce_n) sr2 <= {sr2[W2-2:0], 1'b0};
    end
    assign b1.q7 = sr1[W1-1];
    assign b2.q7 = sr2[W2-1];

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor for the 16-bit reader.
    int   rises1 = 0;
    logic cp1_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            rises1 = 0;
        end else begin
            if (b1.cp && !cp1_prev) rises1++;
            if (!b1.pl_n && b1.cp) overlap++;
            if (b1.data_valid) begin
                vcount1++;
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL u1_unexpected_valid got %0h at %0d", b1.data_out, cyc);
                end else begin
                    e = q1.pop_front();
                    chk("u1_data", 64'(b1.data_out), e.data);
                    chk("u1_valid_cycle", 64'(cyc), 64'(e.cyc));
                    chk("u1_cp_rises", 64'(rises1), 64'(W1));
                end
                rises1 = 0;
            end
        end
        cp1_prev = b1.cp;
    end

    // Monitor for the 8-bit reader, also timing the cp period.
    int   rises2 = 0;
    int   last2 = -1;
    logic cp2_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            rises2 = 0;
            last2 = -1;
        end else begin
            if (b2.cp && !cp2_prev) begin
                rises2++;
                if (last2 >= 0) chk("u2_cp_period", 64'(cyc - last2), 64'(2 * C2));
                last2 = cyc;
            end
            if (!b2.pl_n && b2.cp) overlap++;
            if (b2.data_valid) begin
                vcount2++;
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL u2_unexpected_valid got %0h at %0d", b2.data_out, cyc);
                end else begin
                    e = q2.pop_front();
                    chk("u2_data", 64'(b2.data_out), e.data);
                    chk("u2_valid_cycle", 64'(cyc), 64'(e.cyc));
                    chk("u2_cp_rises", 64'(rises2), 64'(W2));
                end
                rises2 = 0;
                last2 = -1;
            end
        end
        cp2_prev = b2.cp;
    end

    task automatic drain(int maxc);
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0 || b1.busy || b2.busy) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", q1.size() + q2.size());
            q1.delete();
            q2.delete();
        end
    endtask

    task automatic wait_until(int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int c;
        b1.start = 1'b0;
        b2.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pl_n", 64'(b1.pl_n), 64'd1);
        chk("rst_ce_n", 64'(b1.ce_n), 64'd1);
        chk("rst_cp", 64'(b1.cp), 64'd0);
        chk("rst_busy", 64'(b1.busy), 64'd0);
        chk("rst_data", 64'(b1.data_out), 64'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_pl_n", 64'(b1.pl_n), 64'd1);
        chk("idle_busy", 64'(b1.busy), 64'd0);
        chk("idle_data", 64'(b1.data_out), 64'd0);
        chk("idle_valid", 64'(b1.data_valid), 64'd0);

        // Single frame, 16'hA5C3.
        val1 = 16'hA5C3;
        c = cyc;
        b1.start = 1'b1;
        q1.push_back('{64'hA5C3, c + 1 + L1});
        @(negedge clk);
        b1.start = 1'b0;
        chk("load_pl_n_low", 64'(b1.pl_n), 64'd0);
        chk("load_busy", 64'(b1.busy), 64'd1);
        drain(200);
        repeat (5) @(negedge clk);
        chk("hold_data", 64'(b1.data_out), 64'hA5C3);

        // Back-to-back with start held high.
        val1 = 16'h0001;
        c = cyc;
        b1.start = 1'b1;
        q1.push_back('{64'h0001, c + 1 + L1});
        q1.push_back('{64'hFFFF, c + 1 + L1 + L1 + 1});
        wait_until(c + 4);
        val1 = 16'hFFFF;
        wait_until(c + 1 + L1 + 1);
        chk("b2b_pl_n_low", 64'(b1.pl_n), 64'd0);
        b1.start = 1'b0;
        drain(400);

        // Start pulse mid-SHIFT is ignored.
        val1 = 16'h3C5A;
        c = cyc;
        b1.start = 1'b1;
        q1.push_back('{64'h3C5A, c + 1 + L1});
        @(negedge clk);
        b1.start = 1'b0;
        wait_until(c + 20);
        b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        drain(200);
        repeat (10) @(negedge clk);
        chk("ignored_busy", 64'(b1.busy), 64'd0);

        // Reset mid-frame around phase 10.
        val1 = 16'h1234;
        c = cyc;
        b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        wait_until(c + 24);
        chk("pre_abort_ce_n", 64'(b1.ce_n), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_pl_n", 64'(b1.pl_n), 64'd1);
        chk("abort_ce_n", 64'(b1.ce_n), 64'd1);
        chk("abort_cp", 64'(b1.cp), 64'd0);
        chk("abort_busy", 64'(b1.busy), 64'd0);
        chk("abort_data", 64'(b1.data_out), 64'd0);
        chk("abort_valid", 64'(b1.data_valid), 64'd0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        val1 = 16'h5A3C;
        c = cyc;
        b1.start = 1'b1;
        q1.push_back('{64'h5A3C, c + 1 + L1});
        @(negedge clk);
        b1.start = 1'b0;
        drain(200);

        // 8-bit reader, divide-by-5.
        val2 = 8'h96;
        c = cyc;
        b2.start = 1'b1;
        q2.push_back('{64'h96, c + 1 + L2});
        @(negedge clk);
        b2.start = 1'b0;
        drain(300);
        repeat (5) @(negedge clk);

        chk("pl_cp_overlap", 64'(overlap), 64'd0);
        chk("u1_frames", 64'(vcount1), 64'd5);
        chk("u2_frames", 64'(vcount2), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
